conv_mem_params: RTL and testbench

CONV_MEM_PARAMS -- requirements
Module: conv_mem

---
 rtl/conv_mem_params_pkg.sv | 27 ++
 rtl/conv_mem_params_if.sv | 37 +++
 rtl/conv_mem_params_bank.sv | 68 ++++++
 rtl/conv_mem_params.sv | 149 ++++++++++++++
 tb/tb_conv_mem_params.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_mem_params_pkg.sv
// Shared widths, depths and bank codes for the convolution parameter memory.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package conv_mem_params_pkg;

    localparam int BW          = 8;    // weight element width
    localparam int BIAS_BW     = 32;   // bias width
    localparam int SHIFT_BW    = 5;    // quantizer shift width
    localparam int FILTER_LEN  = 3;    // taps per filter
    localparam int FRAME_LEN   = 50;   // frame positions per filter pass
    localparam int VECTOR_LEN  = 13;   // elements per weight vector
    localparam int NUM_FILTERS = 8;

    localparam int VECTOR_BW   = VECTOR_LEN * BW;
    localparam int ADDR_BW     = $clog2(NUM_FILTERS);
    localparam int NUM_BANKS   = 5;
    localparam int BANK_BW     = $clog2(NUM_BANKS);

    typedef enum logic [BANK_BW-1:0] {
        BANK_W0    = 3'd0,
        BANK_W1    = 3'd1,
        BANK_W2    = 3'd2,
        BANK_BIAS  = 3'd3,
        BANK_SHIFT = 3'd4
    } bank_e;

endpackage

// File: rtl/conv_mem_params_if.sv
// Bundle of config-access and parameter-stream signals of the conv parameter memory.
// Latency: n/a (wiring only).
// Backpressure: ready_i is carried for compatibility; the memory never stalls on it.
// Ports: master = requester (drives *_i), slave = memory (drives *_o).
interface conv_mem_params_if;
    import conv_mem_params_pkg::*;

    // stream request and config access
    logic                        cycle_en_i;
    logic                        rd_en_i;
    logic                        wr_en_i;
    logic                        ready_i;
    logic [BANK_BW-1:0]          rd_wr_bank_i;
    logic [ADDR_BW-1:0]          rd_wr_addr_i;
    logic signed [VECTOR_BW-1:0] wr_data_i;

    // responses
    logic signed [VECTOR_BW-1:0] rd_data_o;
    logic [VECTOR_BW-1:0]        data0_o;
    logic [VECTOR_BW-1:0]        data1_o;
    logic [VECTOR_BW-1:0]        data2_o;
    logic [BIAS_BW-1:0]          bias_o;
    logic [SHIFT_BW-1:0]         shift_o;
    logic                        valid_o;
    logic                        last_o;

    modport master (
        output cycle_en_i, rd_en_i, wr_en_i, ready_i, rd_wr_bank_i, rd_wr_addr_i, wr_data_i,
        input  rd_data_o, data0_o, data1_o, data2_o, bias_o, shift_o, valid_o, last_o
    );

    modport slave (
        input  cycle_en_i, rd_en_i, wr_en_i, ready_i, rd_wr_bank_i, rd_wr_addr_i, wr_data_i,
        output rd_data_o, data0_o, data1_o, data2_o, bias_o, shift_o, valid_o, last_o
    );

endinterface

// File: rtl/conv_mem_params_bank.sv
// WIDTH x DEPTH register file: one sync write port, two registered read ports (config + stream).
// Latency: 1 cycle from read enable to read data; reads see pre-write contents on a same-cycle write.
// Backpressure: none; read data registers hold while their enable is low.
// Ports: wr_* write port, rd_* config read port, pr_* parameter-stream read port.
// Macro CONV_MEM_CLEAR_EN: when defined, reset also zeroes the storage array.
module conv_mem_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             pr_en_i,
    input  logic [AW-1:0]    pr_addr_i,
    output logic [WIDTH-1:0] pr_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;
    logic             pr_ok;

    // Addresses past DEPTH (only reachable when DEPTH is not a power of two)
    // drop writes and read back as zero.
    assign wr_ok = 32'(wr_addr_i) < DEPTH;
    assign rd_ok = 32'(rd_addr_i) < DEPTH;
    assign pr_ok = 32'(pr_addr_i) < DEPTH;

`ifdef CONV_MEM_CLEAR_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en_i && wr_ok) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end
`else
    // Contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && wr_ok) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_o <= '0;
            pr_data_o <= '0;
        end else begin
            if (rd_en_i) begin
                rd_data_o <= rd_ok ? mem[rd_addr_i] : '0;
            end
            if (pr_en_i) begin
                pr_data_o <= pr_ok ? mem[pr_addr_i] : '0;
            end
        end
    end

endmodule

// File: rtl/conv_mem_params.sv
// Conv parameter memory: streams tap weights/bias/shift per filter pass, with config read/write.
// Latency: 1 cycle cycle_en_i -> valid_o/data, 1 cycle rd_en_i -> rd_data_o.
// Backpressure: none; ready_i is ignored, every cycle_en_i produces a beat.
// Ports: clk_i, rst_n_i (async active-low), bus (conv_mem_params_if.slave).
// Macro CONV_MEM_CLEAR_EN: when defined, reset also zeroes all stored parameters.
module conv_mem_params #(
    parameter int BW          = conv_mem_params_pkg::BW,
    parameter int BIAS_BW     = conv_mem_params_pkg::BIAS_BW,
    parameter int SHIFT_BW    = conv_mem_params_pkg::SHIFT_BW,
    parameter int FRAME_LEN   = conv_mem_params_pkg::FRAME_LEN,
    parameter int VECTOR_LEN  = conv_mem_params_pkg::VECTOR_LEN,
    parameter int NUM_FILTERS = conv_mem_params_pkg::NUM_FILTERS
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    conv_mem_params_if.slave    bus
);
    import conv_mem_params_pkg::*;

    localparam int VEC_BW = VECTOR_LEN * BW;
    localparam int A_BW   = $clog2(NUM_FILTERS);
    localparam int FRM_BW = $clog2(FRAME_LEN);
    localparam logic [FRM_BW-1:0] FRAME_LAST  = FRM_BW'(FRAME_LEN - 1);
    localparam logic [A_BW-1:0]   FILTER_LAST = A_BW'(NUM_FILTERS - 1);

    logic [FRM_BW-1:0]    frame_cnt;
    logic [A_BW-1:0]      filter_cnt;
    logic                 frame_wrap;
    logic                 filter_wrap;
    logic                 valid_q;
    logic                 last_q;
    logic [BANK_BW-1:0]   rd_sel_q;
    logic [NUM_BANKS-1:0] bank_wr;
    logic [NUM_BANKS-1:0] bank_rd;
    logic [VEC_BW-1:0]    w_rd [FILTER_LEN];
    logic [VEC_BW-1:0]    w_pr [FILTER_LEN];
    logic [BIAS_BW-1:0]   bias_rd;
    logic [BIAS_BW-1:0]   bias_pr;
    logic [SHIFT_BW-1:0]  shift_rd;
    logic [SHIFT_BW-1:0]  shift_pr;
    logic [VEC_BW-1:0]    rd_mux;
    logic                 unused_ready;

    // The stream never stalls, so the consumer's ready is not looked at.
    assign unused_ready = bus.ready_i;

    assign frame_wrap  = (frame_cnt == FRAME_LAST);
    assign filter_wrap = (filter_cnt == FILTER_LAST);

    // Per-bank strobes; codes outside 0..4 match no bank, so such writes vanish.
    always_comb begin
        for (int k = 0; k < NUM_BANKS; k++) begin
            bank_wr[k] = bus.wr_en_i && (bus.rd_wr_bank_i == BANK_BW'(k));
            bank_rd[k] = bus.rd_en_i && (bus.rd_wr_bank_i == BANK_BW'(k));
        end
    end

    for (genvar t = 0; t < FILTER_LEN; t++) begin : g_tap
        conv_mem_bank #(.WIDTH(VEC_BW), .DEPTH(NUM_FILTERS), .AW(A_BW)) u_bank (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .wr_en_i   (bank_wr[t]),
            .wr_addr_i (bus.rd_wr_addr_i),
            .wr_data_i (bus.wr_data_i),
            .rd_en_i   (bank_rd[t]),
            .rd_addr_i (bus.rd_wr_addr_i),
            .rd_data_o (w_rd[t]),
            .pr_en_i   (bus.cycle_en_i),
            .pr_addr_i (filter_cnt),
            .pr_data_o (w_pr[t])
        );
    end

    conv_mem_bank #(.WIDTH(BIAS_BW), .DEPTH(NUM_FILTERS), .AW(A_BW)) u_bias (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (bank_wr[BANK_BIAS]),
        .wr_addr_i (bus.rd_wr_addr_i),
        .wr_data_i (bus.wr_data_i[BIAS_BW-1:0]),
        .rd_en_i   (bank_rd[BANK_BIAS]),
        .rd_addr_i (bus.rd_wr_addr_i),
        .rd_data_o (bias_rd),
        .pr_en_i   (bus.cycle_en_i),
        .pr_addr_i (filter_cnt),
        .pr_data_o (bias_pr)
    );

    conv_mem_bank #(.WIDTH(SHIFT_BW), .DEPTH(NUM_FILTERS), .AW(A_BW)) u_shift (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (bank_wr[BANK_SHIFT]),
        .wr_addr_i (bus.rd_wr_addr_i),
        .wr_data_i (bus.wr_data_i[SHIFT_BW-1:0]),
        .rd_en_i   (bank_rd[BANK_SHIFT]),
        .rd_addr_i (bus.rd_wr_addr_i),
        .rd_data_o (shift_rd),
        .pr_en_i   (bus.cycle_en_i),
        .pr_addr_i (filter_cnt),
        .pr_data_o (shift_pr)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_cnt  <= '0;
            filter_cnt <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            rd_sel_q   <= '1;          // no bank selected: rd_data_o reads as zero
        end else begin
            valid_q <= bus.cycle_en_i;
            last_q  <= bus.cycle_en_i && frame_wrap && filter_wrap;
            if (bus.rd_en_i) begin
                rd_sel_q <= bus.rd_wr_bank_i;
            end
            if (bus.cycle_en_i) begin
                if (frame_wrap) begin
                    frame_cnt  <= '0;
                    filter_cnt <= filter_wrap ? '0 : filter_cnt + 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Each bank's read register holds its own last value, so selecting by the
    // bank code captured at the read keeps rd_data_o stable between reads.
    always_comb begin
        rd_mux = '0;
        case (rd_sel_q)
            BANK_W0:    rd_mux = w_rd[0];
            BANK_W1:    rd_mux = w_rd[1];
            BANK_W2:    rd_mux = w_rd[2];
            BANK_BIAS:  rd_mux = VEC_BW'(bias_rd);
            BANK_SHIFT: rd_mux = VEC_BW'(shift_rd);
            default:    rd_mux = '0;
        endcase
    end

    assign bus.rd_data_o = rd_mux;
    assign bus.data0_o   = w_pr[0];
    assign bus.data1_o   = w_pr[1];
    assign bus.data2_o   = w_pr[2];
    assign bus.bias_o    = bias_pr;
    assign bus.shift_o   = shift_pr;
    assign bus.valid_o   = valid_q;
    assign bus.last_o    = last_q;

endmodule

// File: tb/tb_conv_mem_params.sv
// Scoreboard bench for conv_mem_params: directed config writes/reads and parameter streaming.
// Latency: expects 1-cycle response on both the stream and the config read path.
// Backpressure: ready_i toggled freely; it must not influence anything.
module tb_conv_mem_params;
    import conv_mem_params_pkg::*;

    localparam int VB    = VECTOR_BW;
    localparam int BEATS = FRAME_LEN * NUM_FILTERS;

    typedef struct packed {
        logic [VB-1:0]       d0;
        logic [VB-1:0]       d1;
        logic [VB-1:0]       d2;
        logic [BIAS_BW-1:0]  b;
        logic [SHIFT_BW-1:0] s;
        logic                l;
    } beat_t;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    conv_mem_params_if bus();

    conv_mem_params dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    // reference memory
    logic [VB-1:0]       mw [FILTER_LEN][NUM_FILTERS];
    logic [BIAS_BW-1:0]  mb [NUM_FILTERS];
    logic [SHIFT_BW-1:0] ms [NUM_FILTERS];

    beat_t         exp_beat_q [$];
    logic [VB-1:0] exp_rd_q   [$];

    int   total  = 0;
    int   bad    = 0;
    int   beat   = 0;
    int   cycles = 0;
    logic cyc_flag = 1'b0;
    logic rd_flag  = 1'b0;
    logic done     = 1'b0;

    function automatic logic [VB-1:0] wpat(input int f, input int t);
        logic [VB-1:0] v;
        for (int e = 0; e < VECTOR_LEN; e++) v[e*BW +: BW] = 8'(f*16 + t*4 + e + 1);
        return v;
    endfunction

    function automatic logic [VB-1:0] rd_exp(input logic [2:0] bank, input logic [2:0] addr);
        case (bank)
            3'd0, 3'd1, 3'd2: return mw[int'(bank)][int'(addr)];
            3'd3:             return VB'(mb[int'(addr)]);
            3'd4:             return VB'(ms[int'(addr)]);
            default:          return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; expected responses are queued at issue time.
    task automatic step(input logic cyc, input logic rd, input logic wr,
                        input logic [2:0] bank, input logic [2:0] addr, input logic [VB-1:0] data);
        beat_t e;
        int    f;
        @(posedge clk_i);
        #1;
        bus.cycle_en_i   = cyc;
        bus.rd_en_i      = rd;
        bus.wr_en_i      = wr;
        bus.ready_i      = 1'($urandom_range(0, 1));
        bus.rd_wr_bank_i = bank;
        bus.rd_wr_addr_i = addr;
        bus.wr_data_i    = data;
        if (rd) exp_rd_q.push_back(rd_exp(bank, addr));
        if (cyc) begin
            f    = (beat / FRAME_LEN) % NUM_FILTERS;
            e.d0 = mw[0][f];
            e.d1 = mw[1][f];
            e.d2 = mw[2][f];
            e.b  = mb[f];
            e.s  = ms[f];
            e.l  = (beat % BEATS) == BEATS - 1;
            exp_beat_q.push_back(e);
            beat++;
        end
        // model updated after the expectations: same-cycle accesses see old data
        if (wr) begin
            case (bank)
                3'd0, 3'd1, 3'd2: mw[int'(bank)][int'(addr)] = data;
                3'd3:             mb[int'(addr)] = data[BIAS_BW-1:0];
                3'd4:             ms[int'(addr)] = data[SHIFT_BW-1:0];
                default:          ;
            endcase
        end
    endtask

    always @(posedge clk_i) begin
        cyc_flag = bus.cycle_en_i;
        rd_flag  = bus.rd_en_i;
    end

    // monitor / scoreboard
    always @(negedge clk_i) begin : mon
        beat_t         act;
        beat_t         expb;
        beat_t         last_beat;
        logic [VB-1:0] last_rd;
        logic [VB-1:0] er;
        cycles++;
        act = {bus.data0_o, bus.data1_o, bus.data2_o, bus.bias_o, bus.shift_o, bus.last_o};
        if (!rst_n_i) begin
            exp_beat_q.delete();
            exp_rd_q.delete();
            last_beat = '0;
            last_rd   = '0;
            chk("reset_zero", {bus.valid_o, act, bus.rd_data_o}, '0);
        end else begin
            chk("valid", bus.valid_o, cyc_flag);
            if (bus.valid_o) begin
                if (exp_beat_q.size() == 0) begin
                    chk("beat_unexpected", 1, 0);
                end else begin
                    expb = exp_beat_q.pop_front();
                    chk("beat", act, expb);
                    chk("last", bus.last_o, expb.l);
                    last_beat = expb;
                end
            end else begin
                expb   = last_beat;
                expb.l = 1'b0;
                chk("data_hold", act, expb);
            end
            if (rd_flag) begin
                if (exp_rd_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    er = exp_rd_q.pop_front();
                    chk("rd_data", bus.rd_data_o, er);
                    last_rd = er;
                end
            end else begin
                chk("rd_hold", bus.rd_data_o, last_rd);
            end
        end
        if (done || cycles > 5000) begin
            if (!done) chk("watchdog", cycles, 0);
            chk("beat_q_empty", exp_beat_q.size(), 0);
            chk("rd_q_empty", exp_rd_q.size(), 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    localparam logic [VB-1:0] Z = '0;

    initial begin
        logic [VB-1:0] v;
        logic [2:0]    gaps [12];
        bus.cycle_en_i   = 1'b0;
        bus.rd_en_i      = 1'b0;
        bus.wr_en_i      = 1'b0;
        bus.ready_i      = 1'b0;
        bus.rd_wr_bank_i = '0;
        bus.rd_wr_addr_i = '0;
        bus.wr_data_i    = '0;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            for (int t = 0; t < FILTER_LEN; t++) mw[t][f] = '0;
            mb[f] = '0;
            ms[f] = '0;
        end
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        // load distinct parameters per filter
        for (int f = 0; f < NUM_FILTERS; f++) begin
            for (int t = 0; t < FILTER_LEN; t++) step(0, 0, 1, 3'(t), 3'(f), wpat(f, t));
            step(0, 0, 1, 3'd3, 3'(f), VB'(-1000 + 300*f));   // sign-extended, low 32 kept
            v = '1;
            v[SHIFT_BW-1:0] = 5'(f + 3);                         // junk above the shift field
            step(0, 0, 1, 3'd4, 3'(f), v);
        end
        step(0, 1, 0, 3'd0, 3'd3, Z);
        step(0, 1, 0, 3'd3, 3'd3, Z);
        step(0, 1, 0, 3'd4, 3'd3, Z);

        // tap0 filter 2 = 0x05 in every element, then read it
        v = {VECTOR_LEN{8'h05}};
        step(0, 0, 1, 3'd0, 3'd2, v);
        step(0, 1, 0, 3'd0, 3'd2, Z);
        // bias filter 1 = -7 -> 0xFFFFFFF9 zero-extended
        step(0, 0, 1, 3'd3, 3'd1, VB'(-7));
        step(0, 1, 0, 3'd3, 3'd1, Z);
        // same-cycle read+write returns old, then new
        step(0, 1, 1, 3'd1, 3'd3, {VECTOR_LEN{8'h3C}});
        step(0, 1, 0, 3'd1, 3'd3, Z);
        // illegal bank codes
        step(0, 0, 1, 3'd6, 3'd0, '1);
        step(0, 1, 0, 3'd5, 3'd0, Z);
        step(0, 1, 0, 3'd7, 3'd0, Z);
        for (int b = 0; b < NUM_BANKS; b++) step(0, 1, 0, 3'(b), 3'd0, Z);
        step(0, 0, 0, 3'd0, 3'd0, Z);
        step(0, 0, 0, 3'd0, 3'd0, Z);

        // full pass; write to filter 1 tap0 during its own beat 60
        for (int i = 0; i < BEATS; i++)
            step(1, 0, (i == 60), 3'd0, 3'd1, {VECTOR_LEN{8'hA7}});
        repeat (3) step(0, 0, 0, 3'd0, 3'd0, Z);

        // gapped requests
        gaps = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
        for (int i = 0; i < 12; i++) step(gaps[i][0], 0, 0, 3'd0, 3'd0, Z);

        // run to beat 120 of the pass, then reset mid-sequence
        while ((beat % BEATS) != 121) step(1, 0, 0, 3'd0, 3'd0, Z);
        @(posedge clk_i);
        #1;
        rst_n_i        = 1'b0;
        bus.cycle_en_i = 1'b0;
        bus.rd_en_i    = 1'b0;
        bus.wr_en_i    = 1'b0;
        beat           = 0;
`ifdef CONV_MEM_CLEAR_EN
        for (int f = 0; f < NUM_FILTERS; f++) begin
            for (int t = 0; t < FILTER_LEN; t++) mw[t][f] = '0;
            mb[f] = '0;
            ms[f] = '0;
        end
`endif
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        repeat (3) step(1, 0, 0, 3'd0, 3'd0, Z);
        step(0, 1, 0, 3'd0, 3'd3, Z);
        step(0, 1, 0, 3'd3, 3'd5, Z);
        repeat (3) step(0, 0, 0, 3'd0, 3'd0, Z);
        @(posedge clk_i);
        #1 done = 1'b1;
    end

endmodule
